// File: rtl/serial_datapath.sv
// Shift-register datapath behind serial_ctrl: serial shift/readback load, saturating
// bit counter that flags a complete word, and a parallel update register.
module serial_datapath #(
    parameter int DATA_WIDTH = 8,
    localparam int CNT_W = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  enable_shift_register,
    input  logic                  write_shift_register,
    input  logic                  reset_shift_reg_out,
    input  logic                  enable_data_counter,
    input  logic                  update,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    output logic                  data_ready,
    output logic                  data_out_shift_reg_in,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  update_strobe
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] sr_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  count_step_s;

    // Only plain shifts count; a load or clear in the same cycle takes precedence.
    assign count_step_s = enable_shift_register && !write_shift_register
                          && reset_shift_reg_out && (cnt_r != CNT_MAX);

    // Shift register: clear beats load beats shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r <= {DATA_WIDTH{1'b0}};
        end else if (!reset_shift_reg_out) begin
            sr_r <= {DATA_WIDTH{1'b0}};
        end else if (write_shift_register) begin
            sr_r <= parallel_in;
        end else if (enable_shift_register) begin
            sr_r <= {sr_r[DATA_WIDTH-2:0], data_in};
        end else begin
            sr_r <= sr_r;
        end
    end

    // Bit counter, held at zero while disabled and saturating at DATA_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!enable_data_counter) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (count_step_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Parallel update captures the pre-shift word and pulses the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parallel_out  <= {DATA_WIDTH{1'b0}};
            update_strobe <= 1'b0;
        end else if (update) begin
            parallel_out  <= sr_r;
            update_strobe <= 1'b1;
        end else begin
            parallel_out  <= parallel_out;
            update_strobe <= 1'b0;
        end
    end

    // Gated by the enable so data_ready drops in the same cycle the counter is released.
    assign data_ready            = enable_data_counter && (cnt_r == CNT_MAX);
    assign data_out_shift_reg_in = sr_r[DATA_WIDTH-1];

endmodule

// File: tb/tb_serial_datapath.sv
// Directed bench for serial_datapath: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_serial_datapath;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic       enable_shift_register;
    logic       write_shift_register;
    logic       reset_shift_reg_out;
    logic       enable_data_counter;
    logic       update;
    logic [7:0] parallel_in;
    logic       data_ready;
    logic       data_out_shift_reg_in;
    logic [7:0] parallel_out;
    logic       update_strobe;

    int checks;
    int errors;

    serial_datapath #(.DATA_WIDTH(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .data_in               (data_in),
        .enable_shift_register (enable_shift_register),
        .write_shift_register  (write_shift_register),
        .reset_shift_reg_out   (reset_shift_reg_out),
        .enable_data_counter   (enable_data_counter),
        .update                (update),
        .parallel_in           (parallel_in),
        .data_ready            (data_ready),
        .data_out_shift_reg_in (data_out_shift_reg_in),
        .parallel_out          (parallel_out),
        .update_strobe         (update_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        data_in               = b;
        enable_shift_register = 1'b1;
        tick();
        enable_shift_register = 1'b0;
    endtask

    task automatic do_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_ready"}, data_ready, 1'b0);
        chk1({tag, "_sout"}, data_out_shift_reg_in, 1'b0);
        chk8({tag, "_pout"}, parallel_out, 8'h00);
        chk1({tag, "_strobe"}, update_strobe, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] ld;
        checks                = 0;
        errors                = 0;
        reset                 = 1'b1;
        data_in               = 1'b0;
        enable_shift_register = 1'b0;
        write_shift_register  = 1'b0;
        reset_shift_reg_out   = 1'b1;
        enable_data_counter   = 1'b0;
        update                = 1'b0;
        parallel_in           = 8'h00;
        tick();
        check_all_zero("reset");
        reset               = 1'b0;
        enable_data_counter = 1'b1;

        // 1: shift 1,0,1,0,0,1,0,1 -> 0xA5
        pat = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            shift_bit(pat[i]);
            if (i == 1) chk1("s1_ready_after7", data_ready, 1'b0);
        end
        chk1("s1_ready_after8", data_ready, 1'b1);
        chk1("s1_sout", data_out_shift_reg_in, 1'b1);

        // 2: one-cycle update
        do_update();
        chk8("s2_pout", parallel_out, 8'hA5);
        chk1("s2_strobe_hi", update_strobe, 1'b1);
        tick();
        chk1("s2_strobe_lo", update_strobe, 1'b0);
        chk8("s2_pout_hold", parallel_out, 8'hA5);

        // 9th shift saturates counter, sr = 0x4B
        shift_bit(1'b1);
        chk1("s1_ready_sat", data_ready, 1'b1);
        chk1("s1_sout9", data_out_shift_reg_in, 1'b0);
        // update with shift: pout gets pre-shift 0x4B, sr becomes 0x96
        update                = 1'b1;
        data_in               = 1'b0;
        enable_shift_register = 1'b1;
        tick();
        enable_shift_register = 1'b0;
        chk8("upd_shift_pout", parallel_out, 8'h4B);
        chk1("upd_shift_sout", data_out_shift_reg_in, 1'b1);
        tick();
        update = 1'b0;
        chk8("upd_b2b_pout", parallel_out, 8'h96);
        chk1("upd_b2b_strobe", update_strobe, 1'b1);

        // 3: clear counter, then load 0x3C with shift also requested
        enable_data_counter = 1'b0;
        #1;
        chk1("s3_ready_drop", data_ready, 1'b0);
        tick();
        enable_data_counter   = 1'b1;
        parallel_in           = 8'h3C;
        write_shift_register  = 1'b1;
        enable_shift_register = 1'b1;
        tick();
        write_shift_register  = 1'b0;
        enable_shift_register = 1'b0;
        ld = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            chk1($sformatf("s3_sout%0d", k), data_out_shift_reg_in, ld[7-k]);
            shift_bit(1'b0);
            if (k == 6) chk1("s3_ready_after7", data_ready, 1'b0);
        end
        chk1("s3_ready_after8", data_ready, 1'b1);

        // 4: clear beats load
        parallel_in          = 8'h81;
        write_shift_register = 1'b1;
        tick();
        chk1("s4_load81", data_out_shift_reg_in, 1'b1);
        parallel_in         = 8'hFF;
        reset_shift_reg_out = 1'b0;
        tick();
        write_shift_register = 1'b0;
        reset_shift_reg_out  = 1'b1;
        chk1("s4_clear_sout", data_out_shift_reg_in, 1'b0);
        do_update();
        chk8("s4_clear_pout", parallel_out, 8'h00);

        // 5: drop counter enable at saturation
        chk1("s5_ready_pre", data_ready, 1'b1);
        enable_data_counter = 1'b0;
        #1;
        chk1("s5_ready_same", data_ready, 1'b0);
        tick();
        enable_data_counter = 1'b1;
        #1;
        chk1("s5_ready_reenable", data_ready, 1'b0);
        for (int k = 0; k < 7; k++) shift_bit(1'b1);
        chk1("s5_ready_after7", data_ready, 1'b0);
        shift_bit(1'b1);
        chk1("s5_ready_after8", data_ready, 1'b1);

        // 6: reset mid-shift with update pending
        enable_data_counter = 1'b0;
        tick();
        enable_data_counter = 1'b1;
        for (int k = 0; k < 4; k++) shift_bit(1'b1);
        update = 1'b1;
        tick();
        chk8("s6_pre_pout", parallel_out, 8'hFF);
        chk1("s6_pre_sout", data_out_shift_reg_in, 1'b1);
        reset = 1'b1;
        #1;
        check_all_zero("s6_async");
        tick();
        check_all_zero("s6_held");
        update = 1'b0;
        reset  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            shift_bit(pat[i]);
            if (i == 1) chk1("s6_ready_after7", data_ready, 1'b0);
        end
        chk1("s6_ready_after8", data_ready, 1'b1);
        do_update();
        chk8("s6_pout", parallel_out, 8'hA5);
        chk1("s6_strobe", update_strobe, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
